// File: rtl/bcd_clock_counter.sv
// BCD HH:MM:SS time-of-day counter with 24h/12h format, prescaler, run/pause,
// validated load and tick pulses. Define DAY_COUNTER_EN to add a day-of-week counter.
module bcd_clock_counter #(
  parameter int MODE_24H = 1,
  parameter int TICK_DIV = 1
) (
  input  logic       clk_1hz,
  input  logic       rst_n,
  input  logic       run_en,
  input  logic       time_ow,
  input  logic [3:0] sec_in_o,
  input  logic [3:0] sec_in_t,
  input  logic [3:0] min_in_o,
  input  logic [3:0] min_in_t,
  input  logic [3:0] hr_in_o,
  input  logic [3:0] hr_in_t,
  input  logic       pm_in,
`ifdef DAY_COUNTER_EN
  input  logic [2:0] day_in,
  output logic [2:0] day_out,
  output logic       day_tick,
`endif
  output logic [3:0] sec_out_o,
  output logic [3:0] sec_out_t,
  output logic [3:0] min_out_o,
  output logic [3:0] min_out_t,
  output logic [3:0] hr_out_o,
  output logic [3:0] hr_out_t,
  output logic       pm_out,
  output logic       sec_tick,
  output logic       min_tick,
  output logic       hr_tick,
  output logic       load_err
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [3:0] HR_T_RST = (MODE_24H != 0) ? 4'd0 : 4'd1;
  localparam logic [3:0] HR_O_RST = (MODE_24H != 0) ? 4'd0 : 4'd2;

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0] sec_o_q, sec_o_d, sec_t_q, sec_t_d;
  logic [3:0] min_o_q, min_o_d, min_t_q, min_t_d;
  logic [3:0] hr_o_q, hr_o_d, hr_t_q, hr_t_d;
  logic pm_q, pm_d;
  logic sec_tick_q, sec_tick_d, min_tick_q, min_tick_d, hr_tick_q, hr_tick_d;
  logic load_err_q, load_err_d;
  logic sec_ok, min_ok, hr_ok, day_ok, load_ok, advance, hr_carry, midnight;
`ifdef DAY_COUNTER_EN
  logic [2:0] day_q, day_d;
  logic day_tick_q, day_tick_d;
`endif

  always_comb begin
    sec_ok = (sec_in_t <= 4'd5) && (sec_in_o <= 4'd9);
    min_ok = (min_in_t <= 4'd5) && (min_in_o <= 4'd9);
    if (MODE_24H != 0)
      hr_ok = ((hr_in_t < 4'd2) && (hr_in_o <= 4'd9)) ||
              ((hr_in_t == 4'd2) && (hr_in_o <= 4'd3));
    else
      hr_ok = ((hr_in_t == 4'd0) && (hr_in_o >= 4'd1) && (hr_in_o <= 4'd9)) ||
              ((hr_in_t == 4'd1) && (hr_in_o <= 4'd2));
`ifdef DAY_COUNTER_EN
    day_ok = (day_in <= 3'd6);
`else
    day_ok = 1'b1;
`endif
    load_ok = sec_ok && min_ok && hr_ok && day_ok;
  end

  always_comb begin
    presc_d    = presc_q;
    sec_o_d    = sec_o_q;
    sec_t_d    = sec_t_q;
    min_o_d    = min_o_q;
    min_t_d    = min_t_q;
    hr_o_d     = hr_o_q;
    hr_t_d     = hr_t_q;
    pm_d       = pm_q;
    sec_tick_d = 1'b0;
    min_tick_d = 1'b0;
    hr_tick_d  = 1'b0;
    load_err_d = 1'b0;
    advance    = 1'b0;
    hr_carry   = 1'b0;
    midnight   = 1'b0;
`ifdef DAY_COUNTER_EN
    day_d      = day_q;
    day_tick_d = 1'b0;
`endif

    if (time_ow) begin
      if (load_ok) begin
        presc_d = '0;
        sec_o_d = sec_in_o;
        sec_t_d = sec_in_t;
        min_o_d = min_in_o;
        min_t_d = min_in_t;
        hr_o_d  = hr_in_o;
        hr_t_d  = hr_in_t;
        pm_d    = (MODE_24H != 0) ? 1'b0 : pm_in;
`ifdef DAY_COUNTER_EN
        day_d   = day_in;
`endif
      end else begin
        load_err_d = 1'b1;
      end
    end else if (run_en) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        advance = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    // Seconds/minutes cascade; hr_carry flags the full MM:SS wrap.
    if (advance) begin
      sec_tick_d = 1'b1;
      if (sec_o_q == 4'd9) begin
        sec_o_d = '0;
        if (sec_t_q == 4'd5) begin
          sec_t_d    = '0;
          min_tick_d = 1'b1;
          if (min_o_q == 4'd9) begin
            min_o_d = '0;
            if (min_t_q == 4'd5) begin
              min_t_d   = '0;
              hr_tick_d = 1'b1;
              hr_carry  = 1'b1;
            end else begin
              min_t_d = min_t_q + 4'd1;
            end
          end else begin
            min_o_d = min_o_q + 4'd1;
          end
        end else begin
          sec_t_d = sec_t_q + 4'd1;
        end
      end else begin
        sec_o_d = sec_o_q + 4'd1;
      end
    end

    if (hr_carry) begin
      if ((MODE_24H != 0) && (hr_t_q == 4'd2) && (hr_o_q == 4'd3)) begin
        hr_t_d   = '0;
        hr_o_d   = '0;
        midnight = 1'b1;
      end else if ((MODE_24H == 0) && (hr_t_q == 4'd1) && (hr_o_q == 4'd2)) begin
        hr_t_d = 4'd0;
        hr_o_d = 4'd1;
      end else if ((MODE_24H == 0) && (hr_t_q == 4'd1) && (hr_o_q == 4'd1)) begin
        hr_o_d   = 4'd2;
        pm_d     = ~pm_q;
        midnight = pm_q;
      end else if (hr_o_q == 4'd9) begin
        hr_o_d = '0;
        hr_t_d = hr_t_q + 4'd1;
      end else begin
        hr_o_d = hr_o_q + 4'd1;
      end
    end

`ifdef DAY_COUNTER_EN
    if (midnight) begin
      day_d      = (day_q == 3'd6) ? 3'd0 : day_q + 3'd1;
      day_tick_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_1hz or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      sec_o_q    <= '0;
      sec_t_q    <= '0;
      min_o_q    <= '0;
      min_t_q    <= '0;
      hr_o_q     <= HR_O_RST;
      hr_t_q     <= HR_T_RST;
      pm_q       <= 1'b0;
      sec_tick_q <= 1'b0;
      min_tick_q <= 1'b0;
      hr_tick_q  <= 1'b0;
      load_err_q <= 1'b0;
`ifdef DAY_COUNTER_EN
      day_q      <= '0;
      day_tick_q <= 1'b0;
`endif
    end else begin
      presc_q    <= presc_d;
      sec_o_q    <= sec_o_d;
      sec_t_q    <= sec_t_d;
      min_o_q    <= min_o_d;
      min_t_q    <= min_t_d;
      hr_o_q     <= hr_o_d;
      hr_t_q     <= hr_t_d;
      pm_q       <= pm_d;
      sec_tick_q <= sec_tick_d;
      min_tick_q <= min_tick_d;
      hr_tick_q  <= hr_tick_d;
      load_err_q <= load_err_d;
`ifdef DAY_COUNTER_EN
      day_q      <= day_d;
      day_tick_q <= day_tick_d;
`endif
    end
  end

  assign sec_out_o = sec_o_q;
  assign sec_out_t = sec_t_q;
  assign min_out_o = min_o_q;
  assign min_out_t = min_t_q;
  assign hr_out_o  = hr_o_q;
  assign hr_out_t  = hr_t_q;
  assign pm_out    = pm_q;
  assign sec_tick  = sec_tick_q;
  assign min_tick  = min_tick_q;
  assign hr_tick   = hr_tick_q;
  assign load_err  = load_err_q;
`ifdef DAY_COUNTER_EN
  assign day_out   = day_q;
  assign day_tick  = day_tick_q;
`endif

endmodule

// File: tb/tb_bcd_clock_counter.sv
// Bench for bcd_clock_counter: a 24h/TICK_DIV=1 and a 12h/TICK_DIV=4 instance share
// stimulus and are checked against a seconds-of-day reference model.
module tb_bcd_clock_counter;

  logic clk, rst_n, run_en, time_ow, pm_in;
  logic [3:0] in_so, in_st, in_mo, in_mt, in_ho, in_ht;
  logic [2:0] day_in;

  logic [3:0] a_so, a_st, a_mo, a_mt, a_ho, a_ht;
  logic a_pm, a_stk, a_mtk, a_htk, a_le;
  logic [3:0] b_so, b_st, b_mo, b_mt, b_ho, b_ht;
  logic b_pm, b_stk, b_mtk, b_htk, b_le;
`ifdef DAY_COUNTER_EN
  logic [2:0] a_day, b_day;
  logic a_dtk, b_dtk;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  bcd_clock_counter #(.MODE_24H(1), .TICK_DIV(1)) u_a (
    .clk_1hz(clk), .rst_n(rst_n), .run_en(run_en), .time_ow(time_ow),
    .sec_in_o(in_so), .sec_in_t(in_st), .min_in_o(in_mo), .min_in_t(in_mt),
    .hr_in_o(in_ho), .hr_in_t(in_ht), .pm_in(pm_in),
`ifdef DAY_COUNTER_EN
    .day_in(day_in), .day_out(a_day), .day_tick(a_dtk),
`endif
    .sec_out_o(a_so), .sec_out_t(a_st), .min_out_o(a_mo), .min_out_t(a_mt),
    .hr_out_o(a_ho), .hr_out_t(a_ht), .pm_out(a_pm),
    .sec_tick(a_stk), .min_tick(a_mtk), .hr_tick(a_htk), .load_err(a_le)
  );

  bcd_clock_counter #(.MODE_24H(0), .TICK_DIV(4)) u_b (
    .clk_1hz(clk), .rst_n(rst_n), .run_en(run_en), .time_ow(time_ow),
    .sec_in_o(in_so), .sec_in_t(in_st), .min_in_o(in_mo), .min_in_t(in_mt),
    .hr_in_o(in_ho), .hr_in_t(in_ht), .pm_in(pm_in),
`ifdef DAY_COUNTER_EN
    .day_in(day_in), .day_out(b_day), .day_tick(b_dtk),
`endif
    .sec_out_o(b_so), .sec_out_t(b_st), .min_out_o(b_mo), .min_out_t(b_mt),
    .hr_out_o(b_ho), .hr_out_t(b_ht), .pm_out(b_pm),
    .sec_tick(b_stk), .min_tick(b_mtk), .hr_tick(b_htk), .load_err(b_le)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: time kept as seconds since midnight, per instance.
  int m_secs[2], m_presc[2], m_day[2];
  bit m_st[2], m_mt[2], m_ht[2], m_dt[2], m_le[2];

  function automatic bit is24(int k); return (k == 0); endfunction
  function automatic int div_of(int k); return (k == 0) ? 1 : 4; endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_secs[k] = 0; m_presc[k] = 0; m_day[k] = 0;
      m_st[k] = 0; m_mt[k] = 0; m_ht[k] = 0; m_dt[k] = 0; m_le[k] = 0;
    end
  endtask

  function automatic bit load_valid(int k);
    bit ok;
    int h;
    h  = int'(in_ht) * 10 + int'(in_ho);
    ok = (in_st <= 5) && (in_so <= 9) && (in_mt <= 5) && (in_mo <= 9) && (in_ho <= 9);
    if (is24(k)) ok = ok && (h <= 23);
    else         ok = ok && (h >= 1) && (h <= 12);
`ifdef DAY_COUNTER_EN
    ok = ok && (day_in <= 6);
`endif
    return ok;
  endfunction

  task automatic model_step(input int k);
    int h, nxt;
    m_st[k] = 0; m_mt[k] = 0; m_ht[k] = 0; m_dt[k] = 0; m_le[k] = 0;
    if (time_ow) begin
      if (load_valid(k)) begin
        h = int'(in_ht) * 10 + int'(in_ho);
        if (!is24(k)) h = (h % 12) + (pm_in ? 12 : 0);
        m_secs[k]  = h * 3600 + (int'(in_mt) * 10 + int'(in_mo)) * 60 + int'(in_st) * 10 + int'(in_so);
        m_presc[k] = 0;
        m_day[k]   = int'(day_in);
      end else begin
        m_le[k] = 1;
      end
    end else if (run_en) begin
      m_presc[k]++;
      if (m_presc[k] == div_of(k)) begin
        m_presc[k] = 0;
        nxt = (m_secs[k] + 1) % 86400;
        m_st[k] = 1;
        m_mt[k] = (nxt % 60 == 0);
        m_ht[k] = (nxt % 3600 == 0);
        m_dt[k] = (nxt == 0);
        if (nxt == 0) m_day[k] = (m_day[k] + 1) % 7;
        m_secs[k] = nxt;
      end
    end
  endtask

  function automatic logic [23:0] exp_digits(int k);
    int h, mi, s;
    h  = m_secs[k] / 3600;
    mi = (m_secs[k] / 60) % 60;
    s  = m_secs[k] % 60;
    if (!is24(k)) h = (h % 12 == 0) ? 12 : h % 12;
    return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic exp_pm(int k);
    return is24(k) ? 1'b0 : (m_secs[k] >= 43200);
  endfunction

  task automatic compare_all();
    check("a_time", {8'h0, a_ht, a_ho, a_mt, a_mo, a_st, a_so}, {8'h0, exp_digits(0)});
    check("a_pm", 32'(a_pm), 32'(exp_pm(0)));
    check("a_ticks", {29'h0, a_stk, a_mtk, a_htk}, {29'h0, m_st[0], m_mt[0], m_ht[0]});
    check("a_load_err", 32'(a_le), 32'(m_le[0]));
    check("b_time", {8'h0, b_ht, b_ho, b_mt, b_mo, b_st, b_so}, {8'h0, exp_digits(1)});
    check("b_pm", 32'(b_pm), 32'(exp_pm(1)));
    check("b_ticks", {29'h0, b_stk, b_mtk, b_htk}, {29'h0, m_st[1], m_mt[1], m_ht[1]});
    check("b_load_err", 32'(b_le), 32'(m_le[1]));
`ifdef DAY_COUNTER_EN
    check("a_day", {28'h0, a_dtk, a_day}, {28'h0, m_dt[0], 3'(m_day[0])});
    check("b_day", {28'h0, b_dtk, b_day}, {28'h0, m_dt[1], 3'(m_day[1])});
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic set_load(input int ht, input int ho, input int mt, input int mo,
                          input int st, input int so, input bit pm, input int d);
    in_ht = 4'(ht); in_ho = 4'(ho); in_mt = 4'(mt); in_mo = 4'(mo);
    in_st = 4'(st); in_so = 4'(so); pm_in = pm; day_in = 3'(d);
    time_ow = 1'b1;
  endtask

  // Asserted mid-cycle; outputs must reach reset values before any clock edge.
  task automatic async_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("a_rst_time", {8'h0, a_ht, a_ho, a_mt, a_mo, a_st, a_so}, 32'h000000);
    check("b_rst_time", {7'h0, b_pm, b_ht, b_ho, b_mt, b_mo, b_st, b_so}, 32'h120000);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; run_en = 1'b0; time_ow = 1'b0;
    set_load(0, 0, 0, 0, 0, 0, 0, 0);
    time_ow = 1'b0;
    model_reset();
    #11;
    compare_all();
    #1 rst_n = 1'b1;

    // 24h rollover to midnight with all ticks.
    run_en = 1'b1;
    set_load(2, 3, 5, 9, 5, 8, 0, 6);
    step();
    time_ow = 1'b0;
    step();
    step();
    check("a_midnight_time", {8'h0, a_ht, a_ho, a_mt, a_mo, a_st, a_so}, 32'h000000);
    check("a_midnight_ticks", {29'h0, a_stk, a_mtk, a_htk}, 32'h7);

    // 12h: 11:59:59 AM -> 12:00:00 PM, then 12:59:59 PM -> 01:00:00 PM.
    set_load(1, 1, 5, 9, 5, 9, 0, 2);
    step();
    time_ow = 1'b0;
    repeat (4) step();
    check("b_noon", {7'h0, b_pm, b_ht, b_ho, b_mt, b_mo, b_st, b_so}, 32'h1120000);
    set_load(1, 2, 5, 9, 5, 9, 1, 2);
    step();
    time_ow = 1'b0;
    repeat (4) step();
    check("b_one_pm", {7'h0, b_pm, b_ht, b_ho, b_mt, b_mo, b_st, b_so}, 32'h1010000);

    // Rejected loads.
    set_load(2, 4, 0, 0, 0, 0, 0, 0);
    step();
    check("a_err_24", 32'(a_le), 32'h1);
    set_load(0, 0, 3, 0, 0, 0, 0, 0);
    step();
    check("a_ok_0030", 32'(a_le), 32'h0);
    check("b_err_0030", 32'(b_le), 32'h1);
    set_load(1, 0, 6, 0, 0, 0, 0, 0);
    step();
    check("b_err_1060", 32'(b_le), 32'h1);
    time_ow = 1'b0;
    step();

    // Prescaler: 8 enabled cycles give two seconds, then pause.
    async_reset();
    run_en = 1'b1;
    repeat (8) step();
    check("b_presc_time", {8'h0, b_ht, b_ho, b_mt, b_mo, b_st, b_so}, 32'h120002);
    run_en = 1'b0;
    repeat (5) step();

    // Load on the edge that would otherwise advance the 12h instance.
    async_reset();
    run_en = 1'b1;
    repeat (3) step();
    set_load(0, 5, 0, 6, 0, 7, 0, 1);
    step();
    check("b_load_edge_tick", 32'(b_stk), 32'h0);
    check("b_load_edge_time", {8'h0, b_ht, b_ho, b_mt, b_mo, b_st, b_so}, 32'h050607);
    time_ow = 1'b0;
    repeat (4) step();

    // Async reset mid-count at 14:37:21.
    set_load(1, 4, 3, 7, 2, 1, 0, 3);
    step();
    time_ow = 1'b0;
    repeat (3) step();
    async_reset();

    // Randomized traffic biased towards rollovers.
    for (int i = 0; i < 3000; i++) begin
      run_en  = ($urandom_range(0, 9) != 0);
      time_ow = 1'b0;
      if ($urandom_range(0, 24) == 0) begin
        if ($urandom_range(0, 3) == 0)
          set_load($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                   $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                   1'($urandom_range(0, 1)), $urandom_range(0, 7));
        else
          set_load($urandom_range(0, 2), $urandom_range(0, 9), 5, 9, 5,
                   $urandom_range(0, 9), 1'($urandom_range(0, 1)), $urandom_range(0, 7));
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
